// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage: owns the fetch PC, issues in-order word fetches to a
// variable-latency instruction memory, buffers returned words in a small FIFO
// and hands them to decode with a valid/ready handshake. A redirect (PCSrc)
// restarts fetching at the target, flushes buffered words and marks every
// in-flight response as stale so it is discarded when it returns. A redirect
// to a misaligned target parks the unit in FAULT until reset.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   imem_req_valid/ready/addr   fetch request channel (addr = fetch PC)
//   imem_rsp_valid/data         in-order responses, no backpressure
//   redirect, redirect_target   branch/jump redirect from control
//   instr_valid/ready           decode handshake
//   instr, instr_pc,
//   instr_pcplus4               FIFO head word, its address, address + 4
//   fetch_fault                 sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pcplus4,
  output logic            fetch_fault
);

  localparam int unsigned     PW      = $clog2(DEPTH);
  localparam int unsigned     CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, FAULT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding_q, stale_q, fifo_count;
  logic [PW-1:0]   fifo_rd, fifo_wr, tag_rd, tag_wr;
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] tag_pc    [DEPTH];

  logic            redirect_ok, req_fire, rsp_accept, push, pop;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   outstanding_next;

  // A misaligned redirect only faults; it never retargets the datapath.
  assign redirect_ok = redirect && (state_q == RUN) && (redirect_target[1:0] == 2'b00);

  // Every in-flight request owns a FIFO slot, so a returning word always fits.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = (state_q == RUN) && !reset && (credit_used < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Ignore responses with nothing in flight (e.g. left over across a reset).
  assign rsp_accept = imem_rsp_valid && (outstanding_q != '0);
  // Stale responses, and one landing in a redirect cycle, are dropped.
  assign push       = rsp_accept && (stale_q == '0) && !redirect_ok;

  assign instr_valid   = (fifo_count != '0) && !redirect && (state_q == RUN);
  assign pop           = instr_valid && instr_ready;
  assign instr         = fifo_data[fifo_rd];
  assign instr_pc      = fifo_pc[fifo_rd];
  assign instr_pcplus4 = fifo_pc[fifo_rd] + XLEN'(4);
  assign fetch_fault   = (state_q == FAULT);

  assign outstanding_next = outstanding_q + CW'(req_fire) - CW'(rsp_accept);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && redirect && redirect_target[1:0] != 2'b00) begin
      state_d = FAULT;
    end
  end

  // ---------------------------------------------------------------------------
  // PC, counters and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc      <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
      fifo_count    <= '0;
      fifo_rd       <= '0;
      fifo_wr       <= '0;
      tag_rd        <= '0;
      tag_wr        <= '0;
    end else begin
      if (redirect_ok)   fetch_pc <= redirect_target;
      else if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);

      // The tag queue is never flushed: stale responses still retire their tag.
      if (req_fire)   tag_wr <= tag_wr + PW'(1);
      if (rsp_accept) tag_rd <= tag_rd + PW'(1);

      outstanding_q <= outstanding_next;

      // Everything still in flight after this edge (including a request
      // accepted now) is stale; a response arriving now is already dropped.
      if (redirect_ok)                       stale_q <= outstanding_next;
      else if (rsp_accept && stale_q != '0)  stale_q <= stale_q - CW'(1);

      if (redirect_ok) begin
        fifo_rd    <= '0;
        fifo_wr    <= '0;
        fifo_count <= '0;
      end else begin
        if (push) fifo_wr <= fifo_wr + PW'(1);
        if (pop)  fifo_rd <= fifo_rd + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: storage arrays carry no reset; pointers and counts decide what is
  // valid, so clearing the contents would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (req_fire) tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_data[fifo_wr] <= imem_rsp_data;
      fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_outstanding_bound: assert property (@(posedge clk) disable iff (reset)
    outstanding_q <= DEPTH_C);
  a_stale_bound: assert property (@(posedge clk) disable iff (reset)
    stale_q <= outstanding_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit (DEPTH = 2). A behavioural memory returns
// ~addr as the instruction word after a programmable latency, in order, one
// response per cycle. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        fetch_fault;

  instr_fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pcplus4  (instr_pcplus4),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  // ---------------------------------------------------------------------------
  // Memory model
  // ---------------------------------------------------------------------------
  int          mem_lat = 1;
  int          mcyc    = 0;
  int          req_cnt = 0;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq_addr.delete();
        mq_due.delete();
        req_cnt = 0;
      end else if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(mcyc + mem_lat);
        req_cnt++;
      end
      @(posedge clk);
      #1;
      mcyc++;
      if (mq_addr.size() > 0 && mq_due[0] <= mcyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~mq_addr.pop_front();
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic edge_in();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic step();
    edge_in();
    settle();
  endtask

  task automatic check_word(input string tag, input logic [31:0] pc);
    check1({tag, "_valid"}, instr_valid, 1'b1);
    check({tag, "_pc"},    instr_pc,      pc);
    check({tag, "_instr"}, instr,         ~pc);
    check({tag, "_pc4"},   instr_pcplus4, pc + 32'd4);
  endtask

  // Wait (bounded) for the next word decode will take, then check it.
  task automatic expect_word(input string tag, input logic [31:0] pc, input int budget);
    int n = 0;
    while (!(instr_valid === 1'b1 && instr_ready === 1'b1) && n < budget) begin
      step();
      n++;
    end
    check_word(tag, pc);
  endtask

  // Two reset cycles; returns at mid-cycle of the first cycle out of reset.
  task automatic do_reset(input string tag, input int lat, input logic ird);
    edge_in();
    reset       = 1'b1;
    redirect    = 1'b0;
    mem_lat     = lat;
    instr_ready = ird;
    settle();
    check1({tag, "_rst_req_valid"}, imem_req_valid, 1'b0);
    step();
    check1({tag, "_rst_req_valid2"}, imem_req_valid, 1'b0);
    check1({tag, "_rst_instr_valid"}, instr_valid, 1'b0);
    check1({tag, "_rst_fault"}, fetch_fault, 1'b0);
    edge_in();
    reset = 1'b0;
    settle();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // 1: single-cycle memory, decode always ready
    do_reset("t1", 1, 1'b1);
    check1("t1_c0_req_valid", imem_req_valid, 1'b1);
    check("t1_c0_req_addr", imem_req_addr, 32'h0);
    check1("t1_c0_instr_valid", instr_valid, 1'b0);
    step();
    check1("t1_c1_req_valid", imem_req_valid, 1'b1);
    check("t1_c1_req_addr", imem_req_addr, 32'h4);
    check1("t1_c1_instr_valid", instr_valid, 1'b0);
    step();
    check_word("t1_w0", 32'h0);
    check1("t1_c2_req_valid", imem_req_valid, 1'b0);
    step();
    check_word("t1_w1", 32'h4);
    check("t1_c3_req_addr", imem_req_addr, 32'h8);
    step();
    check1("t1_c4_instr_valid", instr_valid, 1'b0);
    step();
    check_word("t1_w2", 32'h8);
    step();
    check_word("t1_w3", 32'hC);

    // 2: decode backpressure fills both credits, then drains in order
    do_reset("t2", 1, 1'b0);
    repeat (10) step();
    check1("t2_held_req_valid", imem_req_valid, 1'b0);
    check_word("t2_held", 32'h0);
    edge_in();
    check("t2_req_count", 32'(req_cnt), 32'd2);
    instr_ready = 1'b1;
    settle();
    check_word("t2_w0", 32'h0);
    step();
    check_word("t2_w1", 32'h4);
    step();
    check1("t2_gap_instr_valid", instr_valid, 1'b0);
    step();
    check_word("t2_w2", 32'h8);

    // 3: redirect with two requests in flight on a 3-cycle memory
    do_reset("t3", 3, 1'b1);
    repeat (4) step();
    check_word("t3_w0", 32'h0);
    step();
    check_word("t3_w1", 32'h4);
    check("t3_req8_addr", imem_req_addr, 32'h8);
    step();
    check("t3_reqC_addr", imem_req_addr, 32'hC);
    check1("t3_reqC_valid", imem_req_valid, 1'b1);
    edge_in();
    redirect        = 1'b1;
    redirect_target = 32'h100;
    settle();
    check1("t3_redir_instr_valid", instr_valid, 1'b0);
    check1("t3_redir_req_valid", imem_req_valid, 1'b0);
    edge_in();
    redirect = 1'b0;
    settle();
    check("t3_stale", 32'(u_dut.stale_q), 32'd2);
    check1("t3_c8_req_valid", imem_req_valid, 1'b0);
    step();
    check1("t3_c9_req_valid", imem_req_valid, 1'b1);
    check("t3_c9_req_addr", imem_req_addr, 32'h100);
    check1("t3_c9_instr_valid", instr_valid, 1'b0);
    expect_word("t3_tgt0", 32'h100, 8);
    step();
    check_word("t3_tgt1", 32'h104);

    // 4: redirect coinciding with a request accept and a response arrival
    do_reset("t4", 1, 1'b1);
    edge_in();
    redirect        = 1'b1;
    redirect_target = 32'h200;
    settle();
    check1("t4_c1_req_valid", imem_req_valid, 1'b1);
    check("t4_c1_req_addr", imem_req_addr, 32'h4);
    check1("t4_c1_instr_valid", instr_valid, 1'b0);
    edge_in();
    redirect = 1'b0;
    settle();
    check("t4_stale", 32'(u_dut.stale_q), 32'd1);
    check("t4_c2_req_addr", imem_req_addr, 32'h200);
    check1("t4_c2_instr_valid", instr_valid, 1'b0);
    step();
    check1("t4_c3_instr_valid", instr_valid, 1'b0);
    step();
    check_word("t4_w0", 32'h200);
    step();
    check_word("t4_w1", 32'h204);
    edge_in();
    imem_req_ready = 1'b0;
    settle();
    repeat (5) step();
    check("t4_idle_outstanding", 32'(u_dut.outstanding_q), 32'd0);
    check("t4_idle_stale", 32'(u_dut.stale_q), 32'd0);
    check1("t4_idle_instr_valid", instr_valid, 1'b0);
    // refill the FIFO, then redirect while it holds words
    edge_in();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    settle();
    repeat (5) step();
    check1("t4_full_instr_valid", instr_valid, 1'b1);
    edge_in();
    redirect        = 1'b1;
    redirect_target = 32'h300;
    instr_ready     = 1'b1;
    settle();
    check1("t4_masked_instr_valid", instr_valid, 1'b0);
    edge_in();
    redirect = 1'b0;
    settle();
    expect_word("t4_flushed", 32'h300, 8);

    // 5: misaligned redirect faults until reset
    do_reset("t5", 1, 1'b1);
    edge_in();
    redirect        = 1'b1;
    redirect_target = 32'h102;
    settle();
    check1("t5_c1_fault", fetch_fault, 1'b0);
    check1("t5_c1_instr_valid", instr_valid, 1'b0);
    edge_in();
    redirect = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      check1($sformatf("t5_fault_%0d", i), fetch_fault, 1'b1);
      check1($sformatf("t5_req_valid_%0d", i), imem_req_valid, 1'b0);
      check1($sformatf("t5_instr_valid_%0d", i), instr_valid, 1'b0);
      step();
    end
    do_reset("t5r", 1, 1'b1);
    check1("t5r_req_valid", imem_req_valid, 1'b1);
    check("t5r_req_addr", imem_req_addr, 32'h0);

    // 6: PC wrap-around
    edge_in();
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    settle();
    edge_in();
    redirect = 1'b0;
    settle();
    check1("t6_c2_req_valid", imem_req_valid, 1'b1);
    check("t6_c2_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    check1("t6_c3_req_valid", imem_req_valid, 1'b1);
    check("t6_c3_req_addr", imem_req_addr, 32'h0000_0000);
    step();
    check_word("t6_w0", 32'hFFFF_FFFC);
    check("t6_pc4_wrap", instr_pcplus4, 32'h0000_0000);
    step();
    check_word("t6_w1", 32'h0000_0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
